conv_row_slide_par: RTL and testbench

Parametrised single-row convolution engine for the CNN datapath. It captures a K-row strip of a feature map together with a K×K signed kernel. It produces all `OUT_N = IMG_W-K+1` horizontally sliding window results by time-multiplexing `LANES` MAC lanes over `PASSES = ceil(OUT_N/LANES)` passes. It slots into the layer pipeline where a fixed-size, fully parallel slide stage would otherwise sit, and it trades area for latency.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_lane_mac.sv | 70 +++++++
 rtl/conv_row_slide_par.sv | 141 ++++++++++++++
 tb/tb_conv_row_slide_par.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the row-slide convolution engine (conv_row_slide_par).
// Saturation here is signed only; the CONV_RELU_EN clamp is applied inside conv_lane_mac.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STORE,
        DONE
    } conv_state_e;

    // Accumulator wide enough that K*K full-precision products can never overflow.
    function automatic int acc_width(input int pix_w, input int w_w, input int k);
        return pix_w + w_w + $clog2(k * k);
    endfunction

    // Clip a signed value to the signed range of a w-bit result.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // MSB index of element i in a vector of n elements of width w, element 0 at the MSBs.
    function automatic int elem_hi(input int n, input int i, input int w);
        return (n - i) * w - 1;
    endfunction

    // Window (output column) handled by lane l during pass p.
    function automatic int win_col(input int p, input int l, input int lanes);
        return p * lanes + l;
    endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// Sequential K*K MAC lane: one product per cycle, then saturation.
// Optional build macro CONV_RELU_EN clamps negative saturated results to zero.
module conv_lane_mac
    import conv_pkg::*;
#(
    parameter int K     = 5,
    parameter int PIX_W = 9,
    parameter int W_W   = 9,
    parameter int OUT_W = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [K*K*PIX_W-1:0]      win,
    input  logic [K*K*W_W-1:0]        weights,
    output logic signed [OUT_W-1:0]   out,
    output logic                      end_flag
);

    localparam int N     = K * K;
    localparam int ACC_W = acc_width(PIX_W, W_W, K);
    localparam int CNT_W = $clog2(N + 1);

    logic [N*PIX_W-1:0]          pix_sr;
    logic [N*W_W-1:0]            wt_sr;
    logic signed [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]            cnt;
    logic signed [PIX_W-1:0]     pix_cur;
    logic signed [W_W-1:0]       wt_cur;
    logic signed [PIX_W+W_W-1:0] prod;
    logic signed [OUT_W-1:0]     out_sat;

    // Operands are shifted towards the MSBs, so element 0 is consumed first.
    assign pix_cur = pix_sr[N*PIX_W-1 -: PIX_W];
    assign wt_cur  = wt_sr[N*W_W-1 -: W_W];
    assign prod    = pix_cur * wt_cur;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_sr   <= '0;
            wt_sr    <= '0;
            acc      <= '0;
            cnt      <= '0;
            end_flag <= 1'b0;
        end else begin
            end_flag <= 1'b0;
            if (start) begin
                pix_sr <= win;
                wt_sr  <= weights;
                acc    <= '0;
                cnt    <= CNT_W'(N);
            end else if (cnt != '0) begin
                acc    <= acc + ACC_W'(prod);
                pix_sr <= pix_sr << PIX_W;
                wt_sr  <= wt_sr << W_W;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) end_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        out_sat = OUT_W'(sat_signed(64'(acc), OUT_W));
        out     = out_sat;
`ifdef CONV_RELU_EN
        if (out_sat[OUT_W-1]) out = '0;
`endif
    end

endmodule

// File: rtl/conv_row_slide_par.sv
// Single-row convolution engine: LANES MAC lanes time-multiplexed over all sliding windows.
// Build macro CONV_RELU_EN (in conv_lane_mac) selects ReLU output clamping; latency is unchanged.
//
// state | meaning
// IDLE  | waiting for start_flag; strip and kernel latched on acceptance
// LOAD  | drive windows of pass p to the lanes and pulse their start
// RUN   | wait for every lane to report end
// STORE | write valid lane results into the result buffer; next pass or DONE
// DONE  | out holds the new results, end_flag pulses
module conv_row_slide_par
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int PIX_W = 9,
    parameter int W_W   = 9,
    parameter int OUT_W = 15,
    parameter int LANES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_flag,
    input  logic [K*IMG_W*PIX_W-1:0]       in,
    input  logic [K*K*W_W-1:0]             weights,
    output logic [(IMG_W-K+1)*OUT_W-1:0]   out,
    output logic                           end_flag,
    output logic                           busy
);

    localparam int OUT_N  = IMG_W - K + 1;
    localparam int PASSES = (OUT_N + LANES - 1) / LANES;
    localparam int P_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int KK     = K * K;

    conv_state_e state, state_next;

    logic [K*IMG_W*PIX_W-1:0] in_q;
    logic [KK*W_W-1:0]        w_q;
    logic [P_W-1:0]           p;
    logic [OUT_N*OUT_W-1:0]   res_q;
    logic [OUT_N*OUT_W-1:0]   res_next;
    logic                     last_pass;
    logic                     lane_start;
    logic [LANES-1:0]         lane_end;
    logic [KK*PIX_W-1:0]      lane_win [LANES];
    logic signed [OUT_W-1:0]  lane_out [LANES];

    assign last_pass = (p == P_W'(PASSES - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        lane_start = 1'b0;
        end_flag   = 1'b0;
        case (state)
            IDLE:    if (start_flag) state_next = LOAD;
            LOAD: begin
                lane_start = 1'b1;
                state_next = RUN;
            end
            RUN:     if (&lane_end) state_next = STORE;
            STORE:   state_next = last_pass ? DONE : LOAD;
            DONE: begin
                end_flag   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lanes past the last window see zeros; their results are never stored.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_win[l] = '0;
            if (win_col(int'(p), l, LANES) < OUT_N) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        lane_win[l][elem_hi(KK, r*K + c, PIX_W) -: PIX_W] =
                            in_q[elem_hi(K*IMG_W, r*IMG_W + win_col(int'(p), l, LANES) + c, PIX_W) -: PIX_W];
                    end
                end
            end
        end
    end

    always_comb begin
        res_next = res_q;
        if (state == STORE) begin
            for (int l = 0; l < LANES; l++) begin
                if (win_col(int'(p), l, LANES) < OUT_N) begin
                    res_next[elem_hi(OUT_N, win_col(int'(p), l, LANES), OUT_W) -: OUT_W] = lane_out[l];
                end
            end
        end
    end

    // The final pass lands in out on the same edge it lands in the buffer, so out is fresh in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q  <= '0;
            w_q   <= '0;
            p     <= '0;
            res_q <= '0;
            out   <= '0;
        end else begin
            res_q <= res_next;
            if (state == IDLE && start_flag) begin
                in_q <= in;
                w_q  <= weights;
                p    <= '0;
            end
            if (state == STORE) begin
                if (last_pass) out <= res_next;
                else           p   <= p + P_W'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        conv_lane_mac #(
            .K     (K),
            .PIX_W (PIX_W),
            .W_W   (W_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .start    (lane_start),
            .win      (lane_win[l]),
            .weights  (w_q),
            .out      (lane_out[l]),
            .end_flag (lane_end[l])
        );
    end

endmodule

// File: tb/tb_conv_row_slide_par.sv
// Directed bench for conv_row_slide_par: default LANES=8 instance plus a LANES=5 instance.
module tb_conv_row_slide_par;

    localparam int IMG_W = 28;
    localparam int K     = 5;
    localparam int PIX_W = 9;
    localparam int W_W   = 9;
    localparam int OUT_W = 15;
    localparam int OUT_N = IMG_W - K + 1;
`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         start8;
    logic                         start5;
    logic [K*IMG_W*PIX_W-1:0]     in_v;
    logic [K*K*W_W-1:0]           w_v;
    logic [OUT_N*OUT_W-1:0]       out8;
    logic [OUT_N*OUT_W-1:0]       out5;
    logic                         end8, end5, busy8, busy5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_row_slide_par #(.IMG_W(IMG_W), .K(K), .PIX_W(PIX_W), .W_W(W_W), .OUT_W(OUT_W), .LANES(8)) u_dut8 (
        .clk(clk), .reset(reset), .start_flag(start8), .in(in_v), .weights(w_v),
        .out(out8), .end_flag(end8), .busy(busy8)
    );

    conv_row_slide_par #(.IMG_W(IMG_W), .K(K), .PIX_W(PIX_W), .W_W(W_W), .OUT_W(OUT_W), .LANES(5)) u_dut5 (
        .clk(clk), .reset(reset), .start_flag(start5), .in(in_v), .weights(w_v),
        .out(out5), .end_flag(end5), .busy(busy5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0: ones/ones  1: pix=c, centre tap  2: pix=10r+c, tap (3,1)
    // 3: 255 x 255  4: 255 x -256         5: ones x -1
    task automatic set_mode(input int m);
        int pv, wv;
        in_v = '0;
        w_v  = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (m)
                    0, 5:    pv = 1;
                    1:       pv = c;
                    2:       pv = 10*r + c;
                    default: pv = 255;
                endcase
                in_v[(K*IMG_W - r*IMG_W - c)*PIX_W-1 -: PIX_W] = PIX_W'(pv);
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                case (m)
                    0:       wv = 1;
                    1:       wv = (r == 2 && c == 2) ? 1 : 0;
                    2:       wv = (r == 3 && c == 1) ? 1 : 0;
                    3:       wv = 255;
                    4:       wv = -256;
                    default: wv = -1;
                endcase
                w_v[(K*K - r*K - c)*W_W-1 -: W_W] = W_W'(wv);
            end
        end
    endtask

    function automatic logic [OUT_N*OUT_W-1:0] exp_vec(input int m);
        logic [OUT_N*OUT_W-1:0] v;
        int e;
        v = '0;
        for (int j = 0; j < OUT_N; j++) begin
            case (m)
                0:       e = 25;
                1:       e = j + 2;
                2:       e = 31 + j;
                3:       e = 16383;
                4:       e = RELU ? 0 : -16384;
                default: e = RELU ? 0 : -25;
            endcase
            v[(OUT_N - j)*OUT_W-1 -: OUT_W] = OUT_W'(e);
        end
        return v;
    endfunction

    // Cycle 0 is the cycle start is sampled; returns the cycle end_flag is seen.
    // Extra start pulses (pa/pb/pc) go to the LANES=8 instance only.
    task automatic run_conv(input bit sel5, input int pa, input int pb, input int pc,
                            input bit scramble, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        if (sel5) start5 = 1'b1;
        else      start8 = 1'b1;
        tick();
        start5 = 1'b0;
        start8 = 1'b0;
        if (scramble) begin
            in_v = ~in_v;
            w_v  = ~w_v;
        end
        for (int n = 1; n <= 300; n++) begin
            if (!(sel5 ? busy5 : busy8)) busy_ok = 1'b0;
            start8 = !sel5 && (n == pa || n == pb || n == pc);
            if (sel5 ? end5 : end8) begin
                lat = n;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  bok;
        bit  seen_end;
        int  modes [5] = '{0, 1, 3, 4, 5};

        reset  = 1'b0;
        start8 = 1'b0;
        start5 = 1'b0;
        set_mode(0);
        repeat (3) tick();
        check("rst_out",  out8,  '0);
        check("rst_out5", out5,  '0);
        check("rst_busy", busy8, 1'b0);
        check("rst_end",  end8,  1'b0);
        reset = 1'b1;
        tick();

        foreach (modes[i]) begin
            set_mode(modes[i]);
            run_conv(1'b0, -1, -1, -1, 1'b0, lat, bok);
            check($sformatf("m%0d_lat", modes[i]),  lat, 85);
            check($sformatf("m%0d_busy", modes[i]), bok, 1'b1);
            check($sformatf("m%0d_out", modes[i]),  out8, exp_vec(modes[i]));
            tick();
            check($sformatf("m%0d_idle", modes[i]), busy8, 1'b0);
            check($sformatf("m%0d_hold", modes[i]), out8, exp_vec(modes[i]));
        end

        // Re-pulses while busy and in DONE, with inputs changed after acceptance.
        set_mode(2);
        run_conv(1'b0, 10, 84, 85, 1'b1, lat, bok);
        check("rp_lat",  lat,  85);
        check("rp_busy", bok,  1'b1);
        check("rp_out",  out8, exp_vec(2));
        tick();
        start8 = 1'b0;
        check("rp_idle86", busy8, 1'b0);
        check("rp_end86",  end8,  1'b0);
        tick();
        check("rp_idle87", busy8, 1'b0);

        set_mode(2);
        run_conv(1'b1, -1, -1, -1, 1'b0, lat, bok);
        check("l5_lat",  lat,  141);
        check("l5_busy", bok,  1'b1);
        check("l5_out",  out5, exp_vec(2));
        tick();
        check("l5_idle", busy5, 1'b0);

        // Reset at cycle 40 of a run.
        set_mode(1);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (39) tick();
        check("mr_busy40", busy8, 1'b1);
        reset = 1'b0;
        tick();
        check("mr_out",  out8,  '0);
        check("mr_busy", busy8, 1'b0);
        check("mr_end",  end8,  1'b0);
        reset = 1'b1;
        seen_end = 1'b0;
        repeat (100) begin
            tick();
            if (end8) seen_end = 1'b1;
        end
        check("mr_noend", seen_end, 1'b0);
        set_mode(0);
        run_conv(1'b0, -1, -1, -1, 1'b0, lat, bok);
        check("mr_lat", lat,  85);
        check("mr_res", out8, exp_vec(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
